// File: rtl/convolution_coprocessor_pkg.sv
// rtl/convolution_coprocessor_pkg.sv - shared types, width helpers and clamp for the convolution coprocessor
package convolution_coprocessor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_ISSUE,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } state_e;

   function automatic int prod_width(input int dw);
      return 2 * dw;
   endfunction

   function automatic int acc_width(input int dw, input int aw);
      return 2 * dw + aw;
   endfunction

   // Clamp a signed value to the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/convolution_coprocessor_realAdder.sv
// rtl/convolution_coprocessor_realAdder.sv - signed combinational adder used as the MAC accumulator sum
module convolution_coprocessor_realAdder #(
   parameter int DATA_WIDTH = 17
) (
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   output logic signed [DATA_WIDTH-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule

// File: rtl/convolution_coprocessor_controller.sv
// rtl/convolution_coprocessor_controller.sv - 1-D convolution sequencer and MAC over X/H/Y sample RAMs
// Optional output saturation to the product width: CONV_SATURATE_EN.
module convolution_coprocessor_controller
   import convolution_coprocessor_pkg::*;
#(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 5,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   size_x,
   input  logic [ADDR_WIDTH:0]   size_h,
   output logic                  busy,
   output logic                  done,
   output logic                  x_rd_en,
   output logic [ADDR_WIDTH-1:0] x_addr,
   input  logic [DATA_WIDTH-1:0] x_data,
   output logic                  h_rd_en,
   output logic [ADDR_WIDTH-1:0] h_addr,
   input  logic [DATA_WIDTH-1:0] h_data,
   output logic                  y_we,
   output logic [ADDR_WIDTH:0]   y_addr,
   output logic [ACC_WIDTH-1:0]  y_data
);

   localparam int PROD_WIDTH = prod_width(DATA_WIDTH);
   localparam int SW = ADDR_WIDTH + 1;
   localparam int CW = ADDR_WIDTH + 2;
   localparam logic [SW-1:0] SIZE_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_e                      state_q, state_d;
   logic [SW-1:0]               sx_q, sx_d, sh_q, sh_d;
   logic [SW-1:0]               n_q, n_d, i_q, i_d, i_hi_q, i_hi_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        pv_q, pv_d;

   logic [SW-1:0]               sx_in, sh_in, sx_m1, i_lo, i_hi;
   logic [CW-1:0]               lo_wide, last_n;
   logic                        is_last;
   logic signed [PROD_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0] prod_ext, sum, y_val;

   assign sx_in = (size_x > SIZE_MAX) ? SIZE_MAX : size_x;
   assign sh_in = (size_h > SIZE_MAX) ? SIZE_MAX : size_h;

   // Tap window for output n; lo_wide goes negative while n < size_h-1.
   assign lo_wide = {1'b0, n_q} + CW'(1) - {1'b0, sh_q};
   assign i_lo    = lo_wide[CW-1] ? '0 : SW'(lo_wide);
   assign sx_m1   = sx_q - SW'(1);
   assign i_hi    = (n_q < sx_m1) ? n_q : sx_m1;
   assign last_n  = {1'b0, sx_q} + {1'b0, sh_q} - CW'(2);
   assign is_last = ({1'b0, n_q} == last_n);

   assign prod     = PROD_WIDTH'($signed(x_data)) * PROD_WIDTH'($signed(h_data));
   assign prod_ext = ACC_WIDTH'(prod);

   convolution_coprocessor_realAdder #(
      .DATA_WIDTH(ACC_WIDTH)
   ) u_adder (
      .a_i  (acc_q),
      .b_i  (prod_ext),
      .sum_o(sum)
   );

`ifdef CONV_SATURATE_EN
   assign y_val = ACC_WIDTH'(sat_clamp(64'(acc_q), PROD_WIDTH));
`else
   assign y_val = acc_q;
`endif

   assign h_rd_en = x_rd_en;

   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sh_d    = sh_q;
      n_d     = n_q;
      i_d     = i_q;
      i_hi_d  = i_hi_q;
      acc_d   = pv_q ? sum : acc_q;
      pv_d    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      x_rd_en = 1'b0;
      x_addr  = '0;
      h_addr  = '0;
      y_we    = 1'b0;
      y_addr  = '0;
      y_data  = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sx_d = sx_in;
               sh_d = sh_in;
               n_d  = '0;
               state_d = (sx_in == '0 || sh_in == '0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            busy    = 1'b1;
            acc_d   = '0;
            i_d     = i_lo;
            i_hi_d  = i_hi;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            busy    = 1'b1;
            x_rd_en = 1'b1;
            x_addr  = ADDR_WIDTH'(i_q);
            h_addr  = ADDR_WIDTH'(n_q - i_q);
            pv_d    = 1'b1;
            i_d     = i_q + SW'(1);
            if (i_q == i_hi_q) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy    = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            busy   = 1'b1;
            y_we   = 1'b1;
            y_addr = n_q;
            y_data = y_val;
            if (is_last) begin
               state_d = ST_DONE;
            end else begin
               n_d     = n_q + SW'(1);
               state_d = ST_CALC;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sx_q    <= '0;
         sh_q    <= '0;
         n_q     <= '0;
         i_q     <= '0;
         i_hi_q  <= '0;
         acc_q   <= '0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sh_q    <= sh_d;
         n_q     <= n_d;
         i_q     <= i_d;
         i_hi_q  <= i_hi_d;
         acc_q   <= acc_d;
         pv_q    <= pv_d;
      end
   end

endmodule

// File: tb/tb_convolution_coprocessor_controller.sv
// tb/tb_convolution_coprocessor_controller.sv - directed self-checking bench for the convolution coprocessor
module tb_convolution_coprocessor_controller;
   import convolution_coprocessor_pkg::*;

   localparam int DW   = 6;
   localparam int AW   = 5;
   localparam int ACCW = 2 * DW + AW;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [AW:0]     size_x = '0;
   logic [AW:0]     size_h = '0;
   logic            busy, done, x_rd_en, h_rd_en, y_we;
   logic [AW-1:0]   x_addr, h_addr;
   logic [DW-1:0]   x_data = '0;
   logic [DW-1:0]   h_data = '0;
   logic [AW:0]     y_addr;
   logic [ACCW-1:0] y_data;

   logic [DW-1:0]   x_mem [32];
   logic [DW-1:0]   h_mem [32];

   int cyc = 0;
   int t0 = 0;
   int checks = 0;
   int failures = 0;
   int ycnt = 0, xcnt = 0, dcnt = 0, bcnt = 0, d_cyc = -1;
   int y_cap [64];
   int y_cyc [64];
   int exp3;

   convolution_coprocessor_controller dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .size_x (size_x),
      .size_h (size_h),
      .busy   (busy),
      .done   (done),
      .x_rd_en(x_rd_en),
      .x_addr (x_addr),
      .x_data (x_data),
      .h_rd_en(h_rd_en),
      .h_addr (h_addr),
      .h_data (h_data),
      .y_we   (y_we),
      .y_addr (y_addr),
      .y_data (y_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (x_rd_en) x_data <= x_mem[x_addr];
      if (h_rd_en) h_data <= h_mem[h_addr];
   end

   always @(negedge clk) begin
      if (y_we) begin
         ycnt++;
         y_cap[y_addr] = int'($signed(y_data));
         y_cyc[y_addr] = cyc - t0;
      end
      if (x_rd_en) xcnt++;
      if (busy) bcnt++;
      if (done) begin
         dcnt++;
         d_cyc = cyc - t0;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run(input int sx, input int sh, input int pulse_at, input int rst_at);
      int rel;
      int ended;
      @(posedge clk);
      #1;
      ycnt = 0; xcnt = 0; dcnt = 0; bcnt = 0; d_cyc = -1;
      for (int k = 0; k < 64; k++) begin
         y_cap[k] = -999;
         y_cyc[k] = -1;
      end
      t0 = cyc;
      size_x = (AW+1)'(sx);
      size_h = (AW+1)'(sh);
      @(negedge clk);
      start = 1'b1;
      ended = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (rel == rst_at) begin
            chk("rst_pt_issue", int'(x_rd_en), 1);
            chk("rst_pt_x_addr", int'(x_addr), 1);
            chk("rst_pt_h_addr", int'(h_addr), 1);
         end
         if (rst_at >= 0 && rel == rst_at + 1) begin
            chk("rst_mid_strobes", int'({busy, done, x_rd_en, h_rd_en, y_we}), 0);
            chk("rst_mid_addrs", int'({x_addr, h_addr, y_addr}), 0);
            chk("rst_mid_y_data", int'(y_data), 0);
            chk("rst_mid_state", int'(dut.state_q), int'(ST_IDLE));
         end
         start = (rel == pulse_at);
         reset = (rel == rst_at);
         if (dcnt > 0 && rel >= d_cyc + 3) begin
            ended = 1;
            break;
         end
         if (rst_at >= 0 && rel >= rst_at + 30) begin
            ended = 1;
            break;
         end
      end
      start = 1'b0;
      reset = 1'b0;
      chk("run_ended", ended, 1);
   endtask

   task automatic check_t1(input string p);
      chk({p, "_ycnt"}, ycnt, 4);
      chk({p, "_y0"}, y_cap[0], 1);
      chk({p, "_y1"}, y_cap[1], 3);
      chk({p, "_y2"}, y_cap[2], 5);
      chk({p, "_y3"}, y_cap[3], 3);
      chk({p, "_wr0_cyc"}, y_cyc[0], 4);
      chk({p, "_wr3_cyc"}, y_cyc[3], 18);
      chk({p, "_done_cyc"}, d_cyc, 19);
      chk({p, "_dcnt"}, dcnt, 1);
      chk({p, "_reads"}, xcnt, 6);
      chk({p, "_busy_after"}, int'(busy), 0);
   endtask

   initial begin
      for (int k = 0; k < 32; k++) begin
         x_mem[k] = '0;
         h_mem[k] = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset_strobes", int'({busy, done, x_rd_en, h_rd_en, y_we}), 0);
      chk("reset_addrs", int'({x_addr, h_addr, y_addr}), 0);
      chk("reset_y_data", int'(y_data), 0);
      reset = 1'b0;

      // Test 1: X=[1,2,3], H=[1,1]
      x_mem[0] = 6'd1; x_mem[1] = 6'd2; x_mem[2] = 6'd3;
      h_mem[0] = 6'd1; h_mem[1] = 6'd1;
      run(3, 2, -1, -1);
      check_t1("t1");

      // Test 2: single sample
      x_mem[0] = 6'd5; h_mem[0] = 6'b111101;
      run(1, 1, -1, -1);
      chk("t2_ycnt", ycnt, 1);
      chk("t2_y0", y_cap[0], -15);
      chk("t2_wr_cyc", y_cyc[0], 4);
      chk("t2_done_cyc", d_cyc, 5);
      chk("t2_reads", xcnt, 1);

      // Test 3: most-negative samples
      for (int k = 0; k < 4; k++) begin
         x_mem[k] = 6'b100000;
         h_mem[k] = 6'b100000;
      end
`ifdef CONV_SATURATE_EN
      exp3 = 2047;
`else
      exp3 = 4096;
`endif
      run(4, 4, -1, -1);
      chk("t3_ycnt", ycnt, 7);
      chk("t3_y0", y_cap[0], 1024);
      chk("t3_y3", y_cap[3], exp3);
      chk("t3_done_cyc", d_cyc, 38);

      // Test 4: zero-length X
      run(0, 3, -1, -1);
      chk("t4_done_cyc", d_cyc, 1);
      chk("t4_reads", xcnt, 0);
      chk("t4_writes", ycnt, 0);
      chk("t4_busy_cycles", bcnt, 0);

      // Test 5: start re-pulsed mid-run
      x_mem[0] = 6'd1; x_mem[1] = 6'd2; x_mem[2] = 6'd3;
      h_mem[0] = 6'd1; h_mem[1] = 6'd1;
      run(3, 2, 7, -1);
      check_t1("t5");

      // Test 6: reset during ISSUE of n=2, then a fresh run
      run(3, 2, -1, 11);
      chk("t6_writes", ycnt, 2);
      chk("t6_no_done", dcnt, 0);
      chk("t6_y1", y_cap[1], 3);
      run(3, 2, -1, -1);
      check_t1("t6_rerun");

      // Oversized size_x clamps to 32
      for (int k = 0; k < 32; k++) x_mem[k] = 6'(k - 16);
      h_mem[0] = 6'd2;
      run(63, 1, -1, -1);
      chk("clamp_ycnt", ycnt, 32);
      chk("clamp_y0", y_cap[0], -32);
      chk("clamp_y31", y_cap[31], 30);
      chk("clamp_done_cyc", d_cyc, 129);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
